xgmii_test_frame_tx: RTL and testbench
======================================

XGMII_TEST_FRAME_TX -- requirements
Module: xgmii_test_frame_tx

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 64: frame bytes excluding preamble/FCS; multiple of 8, range 16..1512.
REQ-002 SHALL have parameter IFG_WORDS, default 2: idle words inserted after each terminate word; range 1..15.
REQ-003 SHALL have parameter DST_MAC, default 48'hFFFFFFFFFFFF: frame bytes 0-5, MSB first.
REQ-004 SHALL have parameter SRC_MAC, default 48'h02000000_0001: frame bytes 6-11, MSB first.
REQ-005 SHALL have parameter ETHERTYPE, default 16'h88B5: frame bytes 12-13, MSB first.
REQ-006 SHALL have port clk  input  1  sole clock; all logic in this domain.
REQ-007 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port enable  input  1  level request for continuous frame generation.
REQ-009 SHALL have port xgmii_txd  output  64  XGMII data; lane n = bits 8n+7:8n, lane 0 first on wire.
REQ-010 SHALL have port xgmii_txc  output  8  XGMII control; bit n qualifies lane n.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port frame_done  output  1  single-cycle pulse coincident with the terminate word.
REQ-013 SHALL have port frame_count  output  32  completed frames since reset.

Function
REQ-014 SHALL implement states IDLE, START, DATA, TERM, IFG; all outputs registered.
REQ-015 IDLE: txd=64'h0707070707070707, txc=8'hFF; enable sampled high -> START next cycle.
REQ-016 START: txd=64'hD5555555555555FB, txc=8'h01; always -> DATA.
REQ-017 DATA: FRAME_LEN/8 words, txc=8'h00, word counter 0..FRAME_LEN/8-1; last word -> TERM.
REQ-018 Payload byte at frame index k (k>=14) SHALL equal (k + frame_count[7:0]) mod 256; bytes 0-13 from DST_MAC/SRC_MAC/ETHERTYPE.
REQ-019 TERM: terminate word per Configuration; frame_done=1; frame_count increments by 1, wrapping 2^32-1 -> 0.
REQ-020 IFG: exactly IFG_WORDS idle words; at last, enable high -> START, else IDLE.
REQ-021 enable deasserted in START/DATA/TERM/IFG SHALL NOT truncate the frame or shorten IFG.
REQ-022 Latency enable-high-in-IDLE to start word on xgmii_txd SHALL be exactly 1 cycle.
REQ-023 Back-to-back spacing with enable held high SHALL be exactly IFG_WORDS idle words between TERM and next START.
REQ-024 Payload generation SHALL use frame_count value held at frame START, stable for the whole frame.

Reset
REQ-025 rst high SHALL asynchronously force IDLE, idle word on txd/txc, busy=0, frame_done=0, frame_count=0, CRC state=32'hFFFFFFFF.
REQ-026 rst asserted mid-frame SHALL abandon the frame with no terminate word; first post-reset frame uses payload seed 0.

Configuration
REQ-027 Macro XGMII_TEST_FRAME_TX_FCS_EN defined: CRC-32 (poly 0x04C11DB7 reflected, init FFFFFFFF, final inverted) over bytes 0..FRAME_LEN-1; TERM txd lanes 0-3 = CRC LSB first, lane 4=FD, lanes 5-7=07, txc=8'hF0.
REQ-028 Macro undefined: no CRC logic instantiated; TERM txd=64'h07070707070707FD, txc=8'hFF.

Structure
REQ-029 Package xgmii_pkg SHALL hold XGMII_IDLE (8'h07), XGMII_START (8'hFB), XGMII_TERM (8'hFD), preamble/SFD constants, CRC32 polynomial and init, state enum type.
REQ-030 Sub-module xgmii_crc32_64 SHALL compute next CRC state for 8 data bytes combinationally; instantiated only under XGMII_TEST_FRAME_TX_FCS_EN.

Verification
REQ-031 Reset release, enable=0 -> txd=0707070707070707, txc=FF, busy=0, frame_count=0 for 100 cycles.
REQ-032 FRAME_LEN=64, enable one-cycle pulse -> next cycle start word D5555555555555FB/01, 8 data words txc=00, first data word 64'hFFFFFFFFFFFFFFFF lanes 0-5 then 02,00, TERM, frame_count=1.
REQ-033 FCS_EN defined, default parameters -> TERM lanes 0-3 equal software-model CRC-32 of the 64 frame bytes; wire-side checker reports CRC residue 0xDEBB20E3.
REQ-034 enable held high, IFG_WORDS=2, 3 frames -> exactly 2 idle words between each TERM and next START; frame 2 byte 14 = 8'h0F.
REQ-035 rst pulsed during DATA word 3 -> idle word same cycle, no TERM, frame_count=0; next frame byte 14 = 8'h0E.
REQ-036 enable dropped during DATA word 1 -> frame completes with TERM, IFG_WORDS idles, then IDLE, busy=0.

Source files
------------

// File: rtl/xgmii_pkg.sv
// Shared XGMII control characters, preamble/SFD constants, CRC-32 constants
// and the frame-generator state type.
package xgmii_pkg;

  localparam logic [7:0] XGMII_IDLE     = 8'h07;
  localparam logic [7:0] XGMII_START    = 8'hFB;
  localparam logic [7:0] XGMII_TERM     = 8'hFD;
  localparam logic [7:0] XGMII_PREAMBLE = 8'h55;
  localparam logic [7:0] XGMII_SFD      = 8'hD5;

  localparam logic [63:0] XGMII_IDLE_WORD  = {8{XGMII_IDLE}};
  // Start char in lane 0, six preamble bytes, SFD in lane 7
  localparam logic [63:0] XGMII_START_WORD = {XGMII_SFD, {6{XGMII_PREAMBLE}}, XGMII_START};

  localparam logic [31:0] CRC32_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_TERM,
    ST_IFG
  } tx_state_e;

endpackage

// File: rtl/xgmii_crc32_64.sv
// Combinational CRC-32 (reflected) advance over one 64-bit XGMII word,
// lane 0 first.
module xgmii_crc32_64
  import xgmii_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [63:0] data,
  output logic [31:0] crc_out
);

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ CRC32_POLY_REFL) : (r >> 1);
    return r;
  endfunction

  always_comb begin
    crc_out = crc_in;
    for (int n = 0; n < 8; n++)
      crc_out = crc_byte(crc_out, data[8*n +: 8]);
  end

endmodule

// File: rtl/xgmii_test_frame_tx.sv
// Continuous XGMII test-frame generator. Define XGMII_TEST_FRAME_TX_FCS_EN
// to append a CRC-32 FCS in the terminate word.
module xgmii_test_frame_tx
  import xgmii_pkg::*;
#(
  parameter int          FRAME_LEN = 64,
  parameter int          IFG_WORDS = 2,
  parameter logic [47:0] DST_MAC   = 48'hFFFFFFFFFFFF,
  parameter logic [47:0] SRC_MAC   = 48'h02000000_0001,
  parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [63:0] xgmii_txd,
  output logic [7:0]  xgmii_txc,
  output logic        busy,
  output logic        frame_done,
  output logic [31:0] frame_count
);

  localparam int WORDS = FRAME_LEN / 8;
  localparam logic [111:0] HDR = {DST_MAC, SRC_MAC, ETHERTYPE};

  tx_state_e   state, state_nx;
  logic [7:0]  cnt, cnt_nx;
  logic [7:0]  seed;
  logic [63:0] txd_nx, term_d;
  logic [7:0]  txc_nx, term_c;

  // Bytes 0-13 are the header; the rest is a ramp offset by the frame seed
  function automatic logic [63:0] gen_word(input logic [7:0] w, input logic [7:0] s);
    logic [63:0] r;
    int k;
    r = '0;
    for (int n = 0; n < 8; n++) begin
      k = 8 * int'(w) + n;
      if (k < 14) r[8*n +: 8] = HDR[8*(13-k) +: 8];
      else        r[8*n +: 8] = 8'(k) + s;
    end
    return r;
  endfunction

`ifdef XGMII_TEST_FRAME_TX_FCS_EN
  logic [31:0] crc, crc_nx;

  // CRC follows the data word currently on the wire, so at the last data
  // word crc_nx already covers the whole frame.
  xgmii_crc32_64 u_crc (
    .crc_in (crc),
    .data   (xgmii_txd),
    .crc_out(crc_nx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 crc <= CRC32_INIT;
    else if (state == ST_DATA) crc <= crc_nx;
    else                     crc <= CRC32_INIT;
  end

  assign term_d = {{3{XGMII_IDLE}}, XGMII_TERM, ~crc_nx};
  assign term_c = 8'hF0;
`else
  assign term_d = {{7{XGMII_IDLE}}, XGMII_TERM};
  assign term_c = 8'hFF;
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ST_IDLE:  if (enable) state_nx = ST_START;
      ST_START: begin state_nx = ST_DATA; cnt_nx = '0; end
      ST_DATA:  if (cnt == 8'(WORDS - 1)) state_nx = ST_TERM;
                else cnt_nx = cnt + 8'd1;
      ST_TERM:  begin state_nx = ST_IFG; cnt_nx = '0; end
      ST_IFG:   if (cnt == 8'(IFG_WORDS - 1)) state_nx = enable ? ST_START : ST_IDLE;
                else cnt_nx = cnt + 8'd1;
      default:  state_nx = ST_IDLE;
    endcase

    // Outputs are registered: drive the word belonging to the next state
    txd_nx = XGMII_IDLE_WORD;
    txc_nx = 8'hFF;
    case (state_nx)
      ST_START: begin txd_nx = XGMII_START_WORD; txc_nx = 8'h01; end
      ST_DATA:  begin txd_nx = gen_word(cnt_nx, seed); txc_nx = 8'h00; end
      ST_TERM:  begin txd_nx = term_d; txc_nx = term_c; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      seed        <= '0;
      xgmii_txd   <= XGMII_IDLE_WORD;
      xgmii_txc   <= 8'hFF;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      xgmii_txd  <= txd_nx;
      xgmii_txc  <= txc_nx;
      frame_done <= (state_nx == ST_TERM);
      if (state_nx == ST_START) seed <= frame_count[7:0];
      if (state_nx == ST_TERM)  frame_count <= frame_count + 32'd1;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_xgmii_test_frame_tx.sv
// Self-checking bench for xgmii_test_frame_tx: vector table, directed corner
// sequences and a randomized run against a word-queue reference model.
module tb_xgmii_test_frame_tx;

  localparam int          FLEN = 64;
  localparam int          IFG  = 2;
  localparam int          NW   = FLEN / 8;
  localparam logic [47:0] DST  = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] SRC  = 48'h020000000001;
  localparam logic [15:0] ET   = 16'h88B5;
  localparam logic [63:0] IDLE_W  = 64'h0707070707070707;
  localparam logic [63:0] START_W = 64'hD5555555555555FB;

  logic        clk = 1'b0, rst = 1'b0, enable = 1'b0;
  logic [63:0] xgmii_txd;
  logic [7:0]  xgmii_txc;
  logic        busy, frame_done;
  logic [31:0] frame_count;

  xgmii_test_frame_tx #(.FRAME_LEN(FLEN), .IFG_WORDS(IFG), .DST_MAC(DST),
                        .SRC_MAC(SRC), .ETHERTYPE(ET)) dut (
    .clk(clk), .rst(rst), .enable(enable), .xgmii_txd(xgmii_txd),
    .xgmii_txc(xgmii_txc), .busy(busy), .frame_done(frame_done),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  // ---------------- reference model ----------------
  typedef struct packed { logic [63:0] d; logic [7:0] c; logic term; } wexp_t;
  wexp_t       q[$];
  int unsigned m_count;
  logic [63:0] e_d;
  logic [7:0]  e_c;
  logic        e_busy, e_done;
  logic [31:0] e_cnt;

  function automatic logic [7:0] fbyte(input int k, input logic [7:0] seed);
    logic [111:0] hdr;
    hdr = {DST, SRC, ET};
    if (k < 14) return hdr[8*(13-k) +: 8];
    return 8'((k + int'(seed)) % 256);
  endfunction

  function automatic logic [63:0] dword(input int w, input logic [7:0] seed);
    logic [63:0] r;
    for (int n = 0; n < 8; n++) r[8*n +: 8] = fbyte(8*w + n, seed);
    return r;
  endfunction

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] frame_fcs(input logic [7:0] seed);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int k = 0; k < FLEN; k++) c = crc_byte(c, fbyte(k, seed));
    return ~c;
  endfunction

  function automatic wexp_t term_word(input logic [7:0] seed);
    wexp_t w;
`ifdef XGMII_TEST_FRAME_TX_FCS_EN
    w.d = {24'h070707, 8'hFD, frame_fcs(seed)};
    w.c = 8'hF0;
`else
    w.d = 64'h07070707070707FD;
    w.c = 8'hFF;
    if (seed == 8'hAA) w.d = w.d; // seed does not affect the plain terminate word
`endif
    w.term = 1'b1;
    return w;
  endfunction

  // Expected outputs after the next rising edge, given current rst/enable
  task automatic model_step();
    wexp_t w;
    if (rst) begin
      q.delete(); m_count = 0;
      e_d = IDLE_W; e_c = 8'hFF; e_busy = 1'b0; e_done = 1'b0; e_cnt = '0;
      return;
    end
    if (q.size() == 0 && enable) begin
      q.push_back('{d: START_W, c: 8'h01, term: 1'b0});
      for (int i = 0; i < NW; i++) q.push_back('{d: dword(i, m_count[7:0]), c: 8'h00, term: 1'b0});
      q.push_back(term_word(m_count[7:0]));
      for (int i = 0; i < IFG; i++) q.push_back('{d: IDLE_W, c: 8'hFF, term: 1'b0});
    end
    if (q.size() > 0) begin
      w = q.pop_front();
      e_d = w.d; e_c = w.c; e_busy = 1'b1; e_done = w.term;
      if (w.term) m_count++;
    end else begin
      e_d = IDLE_W; e_c = 8'hFF; e_busy = 1'b0; e_done = 1'b0;
    end
    e_cnt = m_count;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic check_out(input string name);
    tests++;
    if ({xgmii_txd, xgmii_txc, busy, frame_done, frame_count} !==
        {e_d, e_c, e_busy, e_done, e_cnt}) begin
      fails++;
      if (fails <= 20)
        $display("FAIL %s @%0t: got txd=%h txc=%h busy=%b done=%b cnt=%0d want txd=%h txc=%h busy=%b done=%b cnt=%0d",
                 name, $time, xgmii_txd, xgmii_txc, busy, frame_done, frame_count,
                 e_d, e_c, e_busy, e_done, e_cnt);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; q.delete(); m_count = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Wait (at negedges) for frame_done, at most maxc cycles
  task automatic wait_done(input int maxc, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    chk(name, 64'(seen), 64'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic en; logic [63:0] d; logic [7:0] c; logic busy; logic done; logic [31:0] cnt;
  } vec_t;
  vec_t tab[13];

  initial begin
    #2_000_000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    wexp_t tw;
    logic [31:0] res;
    int cyc_term, nframe, dw, nstart, dcount;
    bit ok;

    tab[0] = '{1'b1, START_W, 8'h01, 1'b1, 1'b0, 0};
    tab[1] = '{1'b0, 64'h0002FFFFFFFFFFFF, 8'h00, 1'b1, 1'b0, 0};
    tab[2] = '{1'b0, 64'h0F0EB58801000000, 8'h00, 1'b1, 1'b0, 0};
    for (int w = 2; w < NW; w++) tab[w+1] = '{1'b0, dword(w, 8'h00), 8'h00, 1'b1, 1'b0, 0};
    tw = term_word(8'h00);
    tab[9]  = '{1'b0, tw.d, tw.c, 1'b1, 1'b1, 1};
    tab[10] = '{1'b0, IDLE_W, 8'hFF, 1'b1, 1'b0, 1};
    tab[11] = '{1'b0, IDLE_W, 8'hFF, 1'b1, 1'b0, 1};
    tab[12] = '{1'b0, IDLE_W, 8'hFF, 1'b0, 1'b0, 1};

    // Asynchronous reset with no clock edge yet
    #1 rst = 1'b1;
    #1;
    chk("rst_txd", xgmii_txd, IDLE_W);
    chk("rst_txc", 64'(xgmii_txc), 64'hFF);
    chk("rst_busy_done", 64'({busy, frame_done}), 64'd0);
    chk("rst_count", 64'(frame_count), 64'd0);

    // Idle for 100 cycles with enable low
    q.delete(); m_count = 0;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      enable = 1'b0; model_step(); @(negedge clk); check_out("idle_hold");
    end

    // One-cycle enable pulse, word by word
    do_reset();
    res = 32'hFFFFFFFF;
    for (int i = 0; i < 13; i++) begin
      enable = tab[i].en;
      @(negedge clk);
      chk($sformatf("vec%0d_txd", i), xgmii_txd, tab[i].d);
      chk($sformatf("vec%0d_ctl", i), 64'({xgmii_txc, busy, frame_done, frame_count}),
          64'({tab[i].c, tab[i].busy, tab[i].done, tab[i].cnt}));
      if (i >= 1 && i <= NW)
        for (int n = 0; n < 8; n++) res = crc_byte(res, xgmii_txd[8*n +: 8]);
      if (i == 9)
        for (int n = 0; n < 4; n++) res = crc_byte(res, xgmii_txd[8*n +: 8]);
    end
`ifdef XGMII_TEST_FRAME_TX_FCS_EN
    chk("fcs_residue", 64'(res), 64'hDEBB20E3);
`endif

    // Back-to-back frames with enable held high
    do_reset();
    enable = 1'b1;
    cyc_term = -1; nframe = 0; dw = -1;
    for (int cyc = 0; cyc < 60 && !(nframe == 3 && cyc_term >= 0 && !busy); cyc++) begin
      @(negedge clk);
      if (xgmii_txc == 8'h01 && xgmii_txd == START_W) begin
        if (cyc_term >= 0) chk($sformatf("b2b_gap%0d", nframe), 64'(cyc - cyc_term - 1), 64'(IFG));
        nframe++; dw = -1; cyc_term = -1;
        if (nframe == 3) enable = 1'b0;
      end else if (xgmii_txc == 8'h00) begin
        dw++;
        if (nframe == 2 && dw == 1) chk("b2b_f2_byte14", 64'(xgmii_txd[55:48]), 64'h0F);
      end
      if (frame_done) cyc_term = cyc;
    end
    chk("b2b_frames", 64'(nframe), 64'd3);
    chk("b2b_count", 64'(frame_count), 64'd3);

    // Reset during data word 3 abandons the frame and reseeds
    do_reset();
    enable = 1'b1;
    wait_done(20, "mid_first_done");
    enable = 1'b0;
    repeat (4) @(negedge clk);
    enable = 1'b1; @(negedge clk); enable = 1'b0;
    dcount = 0; ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (xgmii_txc == 8'h00) dcount++;
      if (dcount == 4) ok = 1'b1; else @(negedge clk);
    end
    chk("mid_reached_dw3", 64'(ok), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_txd", xgmii_txd, IDLE_W);
    chk("mid_rst_ctl", 64'({xgmii_txc, busy, frame_done, frame_count}), 64'({8'hFF, 1'b0, 1'b0, 32'd0}));
    @(negedge clk); rst = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (frame_done || xgmii_txc != 8'hFF) ok = 1'b1;
    end
    chk("mid_no_term", 64'(ok), 64'd0);
    enable = 1'b1; @(negedge clk); enable = 1'b0;
    nstart = 0;
    for (int i = 0; i < 6 && nstart < 2; i++) begin
      @(negedge clk);
      if (xgmii_txc == 8'h00) nstart++;
    end
    chk("mid_reseed_byte14", 64'(xgmii_txd[55:48]), 64'h0E);

    // Enable dropped during data word 1
    do_reset();
    enable = 1'b1;
    dcount = 0;
    for (int i = 0; i < 10 && dcount < 2; i++) begin
      @(negedge clk);
      if (xgmii_txc == 8'h00) dcount++;
    end
    enable = 1'b0;
    wait_done(20, "drop_term");
    for (int i = 0; i < IFG; i++) begin
      @(negedge clk);
      chk($sformatf("drop_ifg%0d", i), 64'({xgmii_txd, busy}), 64'({IDLE_W, 1'b1}));
    end
    @(negedge clk);
    chk("drop_idle", 64'({xgmii_txd[31:0], xgmii_txc, busy}), 64'({32'h07070707, 8'hFF, 1'b0}));
    repeat (5) @(negedge clk);
    chk("drop_stay", 64'({xgmii_txc, busy, frame_count[7:0]}), 64'({8'hFF, 1'b0, 8'd1}));

    // Randomized enable and occasional reset against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = (!rst && $urandom_range(0, 249) == 0);
      if ($urandom_range(0, 9) == 0) enable = ~enable;
      model_step();
      @(negedge clk);
      check_out("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
